// File: rtl/fifo_write_arbiter.sv
// Purpose : round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Latency : grant 1 cycle after a request seen in IDLE; zero-bubble handover between bursts; write data is combinational.
// Backpres: fifo_almost_full blocks new grants only; fifo_full stalls the current burst (req_ready low, no write).
// Ports   : clk, reset (sync, active-high); req_valid/req_data/req_ready per producer;
//           fifo_full/fifo_almost_full in, fifo_write/fifo_write_data out; grant (one-hot owner), busy (in BURST).
// Option  : define FIFO_WARB_FIXED_PRIO_EN for fixed priority (index 0 highest, no rr_ptr).
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);
    localparam int IDX_WIDTH  = $clog2(NUM_REQ);
    localparam int BEAT_WIDTH = $clog2(MAX_BURST) + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]            state;
    logic [IDX_WIDTH-1:0]  gnt_idx;
    logic [BEAT_WIDTH-1:0] beat_cnt;
    logic [IDX_WIDTH-1:0]  next_idx;
    logic [IDX_WIDTH-1:0]  search_start;
    logic [IDX_WIDTH-1:0]  winner;
    logic                  any_valid;
    logic                  cur_valid;
    logic                  in_burst;
    logic                  beat;
    logic                  release_burst;

    // gnt_idx + 1, wrapping at NUM_REQ (which need not be a power of two)
    assign next_idx = (gnt_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef FIFO_WARB_FIXED_PRIO_EN
    assign search_start = '0;
`else
    logic [IDX_WIDTH-1:0] rr_ptr;

    // In BURST the search is only consumed on release, where it must start
    // past the current owner so that owner comes last.
    assign search_start = (state == ST_BURST) ? next_idx : rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (in_burst && release_burst) begin
            rr_ptr <= next_idx;
        end
    end
`endif

    // First valid requester at or after search_start, modulo NUM_REQ.
    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = search_start;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(search_start) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                winner = IDX_WIDTH'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any_valid = |req_valid;
    assign cur_valid = req_valid[gnt_idx];

    // Outputs are masked during reset so an aborted burst writes nothing.
    assign in_burst      = (state == ST_BURST) && !reset;
    assign beat          = in_burst && cur_valid && !fifo_full;
    // A stalled burst (fifo_full) can still release if the owner drops valid.
    assign release_burst = (beat && (beat_cnt == BEAT_WIDTH'(MAX_BURST - 1))) || !cur_valid;

    assign grant           = in_burst ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign req_ready       = fifo_full ? '0 : grant;
    assign fifo_write      = beat;
    assign fifo_write_data = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign busy            = in_burst;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            gnt_idx  <= '0;
            beat_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (any_valid && !fifo_almost_full) begin
                state    <= ST_BURST;
                gnt_idx  <= winner;
                beat_cnt <= '0;
            end
        end else begin
            if (release_burst) begin
                beat_cnt <= '0;
                if (any_valid && !fifo_almost_full) begin
                    gnt_idx <= winner;
                end else begin
                    state <= ST_IDLE;
                end
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Purpose : randomized scoreboard bench for fifo_write_arbiter against a behavioural owner/queue model.
// Latency : expectations for a cycle are pushed 1ns after the rising edge, compared at the falling edge.
// Backpres: requesters hold valid and data while offered but not accepted; full/almost_full driven randomly.
module tb_fifo_write_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;
`ifdef FIFO_WARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             fifo_almost_full;
    logic             fifo_write;
    logic [W-1:0]     fifo_write_data;
    logic [N-1:0]     grant;
    logic             busy;

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_write       (fifo_write),
        .fifo_write_data  (fifo_write_data),
        .grant            (grant),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] ready;
        logic         busy;
        logic         write;
    } cyc_t;

    cyc_t         exp_q[$];
    logic [W-1:0] wr_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, how many beats it has taken, and
    // where the next idle search starts.
    int           m_owner = -1;
    int           m_beats = 0;
    int           m_ptr   = 0;
    logic [N-1:0] m_acc   = '0;

    function automatic int pick(input int start, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic push_expect();
        cyc_t e;
        e.grant = '0; e.ready = '0; e.busy = 1'b0; e.write = 1'b0;
        if (!reset && m_owner >= 0) begin
            e.grant = N'(1) << m_owner;
            e.busy  = 1'b1;
            e.ready = fifo_full ? '0 : e.grant;
            e.write = req_valid[m_owner] && !fifo_full;
            if (e.write) wr_q.push_back(req_data[m_owner*W +: W]);
        end
        m_acc = e.ready & req_valid;
        exp_q.push_back(e);
    endtask

    task automatic model_step();
        bit took;
        int nxt;
        if (reset) begin
            m_owner = -1; m_beats = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            if (req_valid != '0 && !fifo_almost_full) begin
                m_owner = pick(FIXED ? 0 : m_ptr, req_valid);
                m_beats = 0;
            end
        end else begin
            took = req_valid[m_owner] && !fifo_full;
            if (took) m_beats++;
            if ((took && m_beats == MB) || !req_valid[m_owner]) begin
                nxt = (m_owner + 1) % N;
                m_ptr = nxt;
                if (req_valid != '0 && !fifo_almost_full) begin
                    m_owner = pick(FIXED ? 0 : nxt, req_valid);
                    m_beats = 0;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic drive(input int pv, input int pf, input int pa, input int pr);
        for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !m_acc[i])) begin
                req_valid[i] = ($urandom_range(99) < pv);
                req_data[i*W +: W] = W'($urandom);
            end
        end
        fifo_full        = ($urandom_range(99) < pf);
        fifo_almost_full = ($urandom_range(99) < pa);
        reset            = ($urandom_range(99) < pr);
    endtask

    // Monitor: one expected record per cycle, one expected datum per write.
    initial begin
        cyc_t e;
        logic [W-1:0] d;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (grant !== e.grant || req_ready !== e.ready || busy !== e.busy || fifo_write !== e.write) begin
                    errors++;
                    $display("FAIL ctrl t=%0t got grant=%b ready=%b busy=%b write=%b want grant=%b ready=%b busy=%b write=%b",
                             $time, grant, req_ready, busy, fifo_write, e.grant, e.ready, e.busy, e.write);
                end
                if (fifo_write === 1'b1) begin
                    checks++;
                    if (wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL wdata t=%0t unexpected write data=%h", $time, fifo_write_data);
                    end else begin
                        d = wr_q.pop_front();
                        if (fifo_write_data !== d) begin
                            errors++;
                            $display("FAIL wdata t=%0t got %h want %h", $time, fifo_write_data, d);
                        end
                    end
                end else if (e.write && wr_q.size() != 0) begin
                    void'(wr_q.pop_front());
                end
            end
        end
    end

    // Phases: {cycles, %valid, %full, %almost_full, %reset}
    int phase_tab[4][5] = '{
        '{60,  100, 0,  0,  0},
        '{400, 60,  15, 15, 1},
        '{300, 30,  30, 40, 1},
        '{200, 90,  5,  5,  2}
    };

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0;
        fifo_full = 1'b0; fifo_almost_full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            model_step();
            #1;
            reset = (c < 2);
            push_expect();
        end
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < phase_tab[p][0]; c++) begin
                @(posedge clk);
                model_step();
                #1;
                drive(phase_tab[p][1], phase_tab[p][2], phase_tab[p][3], phase_tab[p][4]);
                push_expect();
            end
        end
        @(posedge clk);
        model_step();
        #1;
        reset = 1'b1; req_valid = '0;
        push_expect();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending records want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin burst arbiter that shares the single write port of the 2-port RAM-buffered FIFO between NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- The arbiter steers the granted producer's data onto the FIFO write port.
- It throttles new grants on the FIFO's almost_full flag and stalls the current burst on full.

Parameters:
- NUM_REQ, 4: number of requesters, min 2.
- DATA_WIDTH, 8: data width; must equal the FIFO data width.
- MAX_BURST, 4: max beats per grant, min 1.
- IDX_WIDTH, $clog2(NUM_REQ): grant index width (localparam).
- BEAT_WIDTH, $clog2(MAX_BURST)+1: beat counter width (localparam).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; a beat is valid&ready on the same bit.
- fifo_full  in  1  FIFO full flag.
- fifo_almost_full  in  1  FIFO almost_full flag.
- fifo_write  out  1  FIFO write strobe.
- fifo_write_data  out  DATA_WIDTH  FIFO write data.
- grant  out  NUM_REQ  one-hot current owner; all zero in IDLE.
- busy  out  1  high in BURST.

Behaviour:
- Reset state: IDLE, rr_ptr=0, gnt_idx=0, beat_cnt=0. Outputs grant=0, busy=0, req_ready=0, fifo_write=0.
- Reset mid-burst aborts the burst; no write is issued in the reset cycle.
- Two states: IDLE and BURST.
- Winner select (combinational): first i with req_valid[i]=1, searching from start index S upward, mod NUM_REQ.
  - S = rr_ptr in IDLE.
  - S = gnt_idx+1 on release from BURST.
- IDLE -> BURST: any req_valid and fifo_almost_full=0. gnt_idx<=winner, beat_cnt<=0.
- No beat occurs in the IDLE cycle, so grant latency is 1 cycle.
- In BURST:
  - req_ready[gnt_idx] = ~fifo_full; all other req_ready bits are 0.
  - fifo_write = req_valid[gnt_idx] & ~fifo_full.
  - fifo_write_data = req_data slice gnt_idx; this output is combinational.
- On a beat: beat_cnt<=beat_cnt+1.
- Release condition, evaluated in the same cycle:
  - (a) a beat occurs with beat_cnt==MAX_BURST-1, or
  - (b) req_valid[gnt_idx]=0.
- On release: rr_ptr<=gnt_idx+1 mod NUM_REQ.
  - If another requester is valid and fifo_almost_full=0: go directly to BURST with the new winner. This is a zero-bubble handover.
  - Otherwise: go to IDLE.
- fifo_full=1 in BURST: hold state, no beat, beat_cnt unchanged. Deassertion of valid still releases.
- fifo_almost_full only blocks new grants; the current burst continues until full.
- The granted requester is never re-granted on release while others are valid. On handover it is selected only if it is the sole valid requester.
- Simultaneous requests in IDLE: the lowest index at or after rr_ptr wins.
- Wrap: rr_ptr goes from NUM_REQ-1 to 0.
- Requesters must hold data stable while valid&~ready. Violations are not detected.

Optional Feature:
- Macro: FIFO_WARB_FIXED_PRIO_EN.
- Defined: winner search always starts at index 0, giving fixed priority (lowest index highest). rr_ptr is not implemented. The burst limit and release rules are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single requester: req1 valid with data 0x11..0x16 (6 beats), MAX_BURST=4, fifo idle. Expect 0x11..0x14 written on 4 consecutive cycles after the 1-cycle grant. Release, then re-grant to req1 in BURST with no IDLE cycle (sole valid). Then 0x15, 0x16 written.
- All 4 valid continuously from reset. Expect grant order 0,1,2,3,0 with exactly 4 beats each and no bubble between bursts. fifo_write stays high every cycle after the first.
- fifo_full pulse: assert full for 3 cycles mid-burst on req2. Expect req_ready[2]=0 and fifo_write=0 for those 3 cycles, beat_cnt held. Burst resumes with its remaining beats.
- almost_full=1 in IDLE with req0 valid: no grant while asserted. Drop almost_full: grant appears the next cycle. Raise almost_full mid-burst: burst completes.
- Valid drop: req3 deasserts valid after 2 beats. Expect release that cycle, rr_ptr=0, next winner req0 if valid.
- Reset asserted during the second beat of a burst. Expect grant=0, busy=0, fifo_write=0 the next cycle. The first grant after reset goes to req0.
- With FIFO_WARB_FIXED_PRIO_EN defined and req1, req2 continuously valid: req1 wins every burst, and req2 is granted only when req1 deasserts.
